// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two dmem requesters, the arbiter and the data memory.
// The arbiter connects via the slave modport; the requester/memory side via master.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p1_req;
    logic        p0_we;
    logic        p1_we;
    logic [31:0] p0_addr;
    logic [31:0] p1_addr;
    logic [31:0] p0_wdata;
    logic [31:0] p1_wdata;
    logic [2:0]  p0_size;
    logic [2:0]  p1_size;
    logic        p0_gnt;
    logic        p1_gnt;
    logic        p0_rvalid;
    logic        p1_rvalid;
    logic [31:0] p0_rdata;
    logic [31:0] p1_rdata;
    logic        p0_err;
    logic        p1_err;
    logic        m_we;
    logic [31:0] m_a;
    logic [31:0] m_wd;
    logic [2:0]  m_DextControl;
    logic [31:0] m_rd;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
        input  p0_wdata, p1_wdata, p0_size, p1_size, m_rd,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
        output p0_err, p1_err, m_we, m_a, m_wd, m_DextControl
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
        output p0_wdata, p1_wdata, p0_size, p1_size, m_rd,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
        input  p0_err, p1_err, m_we, m_a, m_wd, m_DextControl
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port single-cycle scheduler in front of the data memory: port 0 has priority,
// port 1 is forced through after MAX_WAIT refusals. Misaligned accesses complete but never write.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input logic           clk,
    input logic           reset_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        p0_gnt, p1_gnt, any_gnt;
    logic        sel_we, err;
    logic [31:0] sel_addr, sel_wdata, resp_data;
    logic [2:0]  sel_size;

    logic        p0_rvalid_q, p1_rvalid_q;
    logic        p0_err_q, p1_err_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;

    always_comb begin
        p1_gnt = reset_n && bus.p1_req && (!bus.p0_req || (wait_cnt_q == MaxWait));
        p0_gnt = reset_n && bus.p0_req && !p1_gnt;
        any_gnt = p0_gnt || p1_gnt;
    end

    // Request fields of the winning port; all zero when nothing is granted.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_size  = '0;
        if (p0_gnt) begin
            sel_we    = bus.p0_we;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_wdata;
            sel_size  = bus.p0_size;
        end else if (p1_gnt) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
            sel_size  = bus.p1_size;
        end
    end

    always_comb begin
        case (sel_size)
            3'b000:  err = 1'b0;
            3'b001:  err = (sel_addr[1:0] == 2'b11);
            default: err = (sel_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        resp_data = (!sel_we && !err) ? bus.m_rd : '0;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.p1_req || p1_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            p0_rvalid_q <= p0_gnt;
            p1_rvalid_q <= p1_gnt;
            p0_err_q    <= p0_gnt && err;
            p1_err_q    <= p1_gnt && err;
            if (p0_gnt) begin
                p0_rdata_q <= resp_data;
            end
            if (p1_gnt) begin
                p1_rdata_q <= resp_data;
            end
        end
    end

    assign bus.p0_gnt        = p0_gnt;
    assign bus.p1_gnt        = p1_gnt;
    assign bus.m_we          = any_gnt && sel_we && !err;
    assign bus.m_a           = sel_addr;
    assign bus.m_wd          = sel_wdata;
    assign bus.m_DextControl = sel_size;
    assign bus.p0_rvalid     = p0_rvalid_q;
    assign bus.p1_rvalid     = p1_rvalid_q;
    assign bus.p0_err        = p0_err_q;
    assign bus.p1_err        = p1_err_q;
    assign bus.p0_rdata      = p0_rdata_q;
    assign bus.p1_rdata      = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: small dmem behind the arbiter, byte-array reference model,
// directed scenarios plus randomized back-to-back traffic.
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Data memory: asynchronous read, lane writes selected by size and low address bits.
    logic [31:0] mem [64] = '{default: 32'h0};
    assign bus.m_rd = mem[bus.m_a[7:2]];
    always @(posedge clk) begin
        if (bus.m_we) begin
            case (bus.m_DextControl)
                3'b000:  mem[bus.m_a[7:2]][8*bus.m_a[1:0] +: 8] <= bus.m_wd[7:0];
                3'b001:  mem[bus.m_a[7:2]][16*bus.m_a[1] +: 16] <= bus.m_wd[15:0];
                default: mem[bus.m_a[7:2]] <= bus.m_wd;
            endcase
        end
    end

    logic [7:0] refmem [256] = '{default: 8'h0};
    int n_checks = 0;
    int n_pass = 0;

    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] size, output bit e, output bit mwe,
                                output logic [31:0] rd);
        logic [7:0] a;
        int nbytes;
        a = addr[7:0];
        e = (size == 3'b001 && addr[1:0] == 2'b11) ||
            (size != 3'b000 && size != 3'b001 && addr[1:0] != 2'b00);
        mwe = we && !e;
        rd = '0;
        if (!we && !e) begin
            for (int i = 0; i < 4; i++) rd[8*i +: 8] = refmem[{a[7:2], 2'b00} + 8'(i)];
        end
        if (mwe) begin
            nbytes = (size == 3'b000) ? 1 : (size == 3'b001) ? 2 : 4;
            for (int i = 0; i < nbytes; i++) refmem[a + 8'(i)] = wd[8*i +: 8];
        end
    endtask

    task automatic clear_reqs();
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0; bus.p0_size = 0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0; bus.p1_size = 0;
    endtask

    // One single-port access; returns what the DUT showed in the grant cycle and after it.
    task automatic access(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] size,
                          output logic g, output logic mwe, output logic [31:0] ma,
                          output logic rv, output logic e, output logic [31:0] rd,
                          output logic orv);
        @(negedge clk);
        clear_reqs();
        if (port == 1'b0) begin
            bus.p0_req = 1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
            bus.p0_size = size;
        end else begin
            bus.p1_req = 1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
            bus.p1_size = size;
        end
        #1;
        g = port ? bus.p1_gnt : bus.p0_gnt;
        mwe = bus.m_we;
        ma = bus.m_a;
        @(posedge clk);
        #1;
        rv  = port ? bus.p1_rvalid : bus.p0_rvalid;
        e   = port ? bus.p1_err : bus.p0_err;
        rd  = port ? bus.p1_rdata : bus.p0_rdata;
        orv = port ? bus.p0_rvalid : bus.p1_rvalid;
        bus.p0_req = 0;
        bus.p1_req = 0;
    endtask

    task automatic test_reset();
        clear_reqs();
        reset_n = 0;
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h10; bus.p0_wdata = 32'h12345678;
        bus.p0_size = 3'b010;
        bus.p1_req = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.p0_gnt !== 1'b0) $display("FAIL reset_p0_gnt got %b want 0", bus.p0_gnt); else n_pass++;
        n_checks++; if (bus.p1_gnt !== 1'b0) $display("FAIL reset_p1_gnt got %b want 0", bus.p1_gnt); else n_pass++;
        n_checks++; if (bus.m_we !== 1'b0) $display("FAIL reset_m_we got %b want 0", bus.m_we); else n_pass++;
        n_checks++; if (bus.m_a !== 32'h0) $display("FAIL reset_m_a got %h want 0", bus.m_a); else n_pass++;
        n_checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) $display("FAIL reset_rvalid got %b want 00", {bus.p0_rvalid, bus.p1_rvalid}); else n_pass++;
        n_checks++; if ({bus.p0_err, bus.p1_err} !== 2'b00) $display("FAIL reset_err got %b want 00", {bus.p0_err, bus.p1_err}); else n_pass++;
        n_checks++; if ({bus.p0_rdata, bus.p1_rdata} !== 64'h0) $display("FAIL reset_rdata got %h want 0", {bus.p0_rdata, bus.p1_rdata}); else n_pass++;
        n_checks++; if (mem[4] !== 32'h0) $display("FAIL reset_no_write got %h want 0", mem[4]); else n_pass++;
        @(negedge clk);
        clear_reqs();
        reset_n = 1;
    endtask

    task automatic test_store_load();
        logic g, mwe, rv, e, orv, xe, xmwe;
        logic [31:0] ma, rd, xrd;
        model_access(1, 32'h10, 32'hDEADBEEF, 3'b010, xe, xmwe, xrd);
        access(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if (g !== 1'b1) $display("FAIL sw_gnt got %b want 1", g); else n_pass++;
        n_checks++; if (mwe !== 1'b1) $display("FAIL sw_m_we got %b want 1", mwe); else n_pass++;
        n_checks++; if (ma !== 32'h10) $display("FAIL sw_m_a got %h want 10", ma); else n_pass++;
        n_checks++; if ({rv, e} !== 2'b10) $display("FAIL sw_rvalid_err got %b want 10", {rv, e}); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL sw_rdata got %h want 0", rd); else n_pass++;
        model_access(0, 32'h10, 32'h0, 3'b010, xe, xmwe, xrd);
        access(0, 0, 32'h10, 32'h0, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if (g !== 1'b1) $display("FAIL lw_gnt got %b want 1", g); else n_pass++;
        n_checks++; if (mwe !== 1'b0) $display("FAIL lw_m_we got %b want 0", mwe); else n_pass++;
        n_checks++; if ({rv, e} !== 2'b10) $display("FAIL lw_rvalid_err got %b want 10", {rv, e}); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h want deadbeef", rd); else n_pass++;
        n_checks++; if (orv !== 1'b0) $display("FAIL lw_other_rvalid got %b want 0", orv); else n_pass++;
    endtask

    task automatic test_lanes();
        logic g, mwe, rv, e, orv, xe, xmwe;
        logic [31:0] ma, rd, xrd;
        model_access(1, 32'h21, 32'hAA, 3'b000, xe, xmwe, xrd);
        access(0, 1, 32'h21, 32'hAA, 3'b000, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if ({g, mwe, e} !== 3'b110) $display("FAIL sb_gnt_we_err got %b want 110", {g, mwe, e}); else n_pass++;
        model_access(1, 32'h22, 32'h1234, 3'b001, xe, xmwe, xrd);
        access(0, 1, 32'h22, 32'h1234, 3'b001, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if ({g, mwe, e} !== 3'b110) $display("FAIL sh_gnt_we_err got %b want 110", {g, mwe, e}); else n_pass++;
        model_access(0, 32'h20, 32'h0, 3'b010, xe, xmwe, xrd);
        access(0, 0, 32'h20, 32'h0, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if (rd[31:8] !== 24'h1234AA) $display("FAIL lanes_rdata got %h want 1234aa", rd[31:8]); else n_pass++;
        n_checks++; if (rd !== xrd) $display("FAIL lanes_model got %h want %h", rd, xrd); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL lanes_err got %b want 0", e); else n_pass++;
    endtask

    task automatic test_misaligned();
        logic g, mwe, rv, e, orv, xe, xmwe;
        logic [31:0] ma, rd, xrd;
        model_access(1, 32'h14, 32'hCAFEF00D, 3'b010, xe, xmwe, xrd);
        access(1, 1, 32'h14, 32'hCAFEF00D, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if ({g, mwe, rv, e} !== 4'b1110) $display("FAIL p1_sw_ok got %b want 1110", {g, mwe, rv, e}); else n_pass++;
        model_access(1, 32'h13, 32'h11111111, 3'b010, xe, xmwe, xrd);
        access(1, 1, 32'h13, 32'h11111111, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if ({g, mwe} !== 2'b10) $display("FAIL mis_sw_gnt_we got %b want 10", {g, mwe}); else n_pass++;
        n_checks++; if ({rv, e} !== 2'b11) $display("FAIL mis_sw_rvalid_err got %b want 11", {rv, e}); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL mis_sw_rdata got %h want 0", rd); else n_pass++;
        model_access(1, 32'h17, 32'h2222, 3'b001, xe, xmwe, xrd);
        access(1, 1, 32'h17, 32'h2222, 3'b001, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if ({g, mwe} !== 2'b10) $display("FAIL mis_sh_gnt_we got %b want 10", {g, mwe}); else n_pass++;
        n_checks++; if ({rv, e} !== 2'b11) $display("FAIL mis_sh_rvalid_err got %b want 11", {rv, e}); else n_pass++;
        model_access(0, 32'h10, 32'h0, 3'b010, xe, xmwe, xrd);
        access(0, 0, 32'h10, 32'h0, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL mis_word10 got %h want deadbeef", rd); else n_pass++;
        model_access(0, 32'h14, 32'h0, 3'b010, xe, xmwe, xrd);
        access(0, 0, 32'h14, 32'h0, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL mis_word14 got %h want cafef00d", rd); else n_pass++;
    endtask

    task automatic test_starvation();
        logic prev0, prev1, exp1, xe, xmwe;
        logic [31:0] w10, w14;
        model_access(0, 32'h10, 32'h0, 3'b010, xe, xmwe, w10);
        model_access(0, 32'h14, 32'h0, 3'b010, xe, xmwe, w14);
        prev0 = 0;
        prev1 = 0;
        @(negedge clk);
        clear_reqs();
        bus.p0_req = 1; bus.p0_addr = 32'h10; bus.p0_size = 3'b010;
        bus.p1_req = 1; bus.p1_addr = 32'h14; bus.p1_size = 3'b010;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            // Port 1 gets every (MAX_WAIT+1)-th slot under continuous contention.
            exp1 = ((k % (MAX_WAIT + 1)) == MAX_WAIT);
            n_checks++; if ({bus.p0_gnt, bus.p1_gnt} !== {!exp1, exp1}) $display("FAIL starve_gnt cycle %0d got %b%b want %b%b", k, bus.p0_gnt, bus.p1_gnt, !exp1, exp1); else n_pass++;
            if (k > 0) begin
                n_checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== {prev0, prev1}) $display("FAIL starve_rvalid cycle %0d got %b%b want %b%b", k, bus.p0_rvalid, bus.p1_rvalid, prev0, prev1); else n_pass++;
            end
            if (k > 0 && prev1) begin
                n_checks++; if (bus.p1_rdata !== w14) $display("FAIL starve_p1_rdata got %h want %h", bus.p1_rdata, w14); else n_pass++;
            end
            if (k > 0 && prev0) begin
                n_checks++; if (bus.p0_rdata !== w10) $display("FAIL starve_p0_rdata got %h want %h", bus.p0_rdata, w10); else n_pass++;
            end
            prev0 = !exp1;
            prev1 = exp1;
        end
        @(posedge clk);
        #1;
        n_checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== {prev0, prev1}) $display("FAIL starve_last_rvalid got %b%b want %b%b", bus.p0_rvalid, bus.p1_rvalid, prev0, prev1); else n_pass++;
        clear_reqs();
    endtask

    task automatic test_back_to_back();
        logic g, mwe, rv, e, orv, xe, xmwe;
        logic [31:0] ma, rd, xrd, addr, wd;
        logic [2:0] size;
        bit port, we;
        int fails_before;
        for (int n = 0; n < 60; n++) begin
            port = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            addr = 32'($urandom_range(0, 63)) * 4;
            case ($urandom_range(0, 2))
                0: begin size = 3'b000; addr[1:0] = 2'($urandom_range(0, 3)); end
                1: begin
                    size = 3'b001;
                    case ($urandom_range(0, 2))
                        0: addr[1:0] = 2'b00;
                        1: addr[1:0] = 2'b10;
                        default: addr[1:0] = 2'b11;
                    endcase
                end
                default: begin
                    size = 3'($urandom_range(2, 7));
                    if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
                end
            endcase
            fails_before = n_checks - n_pass;
            model_access(we, addr, wd, size, xe, xmwe, xrd);
            access(port, we, addr, wd, size, g, mwe, ma, rv, e, rd, orv);
            n_checks++; if (g !== 1'b1) $display("FAIL rnd_gnt #%0d got %b want 1", n, g); else n_pass++;
            n_checks++; if (mwe !== xmwe) $display("FAIL rnd_m_we #%0d got %b want %b", n, mwe, xmwe); else n_pass++;
            n_checks++; if (ma !== addr) $display("FAIL rnd_m_a #%0d got %h want %h", n, ma, addr); else n_pass++;
            n_checks++; if (rv !== 1'b1) $display("FAIL rnd_rvalid #%0d got %b want 1", n, rv); else n_pass++;
            n_checks++; if (e !== xe) $display("FAIL rnd_err #%0d got %b want %b", n, e, xe); else n_pass++;
            n_checks++; if (rd !== xrd) $display("FAIL rnd_rdata #%0d got %h want %h", n, rd, xrd); else n_pass++;
            n_checks++; if (orv !== 1'b0) $display("FAIL rnd_other_rvalid #%0d got %b want 0", n, orv); else n_pass++;
            if (n_checks - n_pass != fails_before)
                $display("  access #%0d port=%0d we=%0d addr=%h size=%b wd=%h", n, port, we, addr, size, wd);
        end
    endtask

    task automatic test_reset_mid();
        logic g, mwe, rv, e, orv, xe, xmwe;
        logic [31:0] ma, rd, xrd, old10;
        model_access(0, 32'h10, 32'h0, 3'b010, xe, xmwe, old10);
        @(negedge clk);
        clear_reqs();
        bus.p0_req = 1; bus.p0_addr = 32'h10; bus.p0_size = 3'b010;
        @(posedge clk);
        #1;
        bus.p0_we = 1; bus.p0_wdata = 32'h55AA55AA;
        reset_n = 0;
        #1;
        n_checks++; if ({bus.p0_rvalid, bus.p0_err} !== 2'b00) $display("FAIL midrst_rvalid_err got %b want 00", {bus.p0_rvalid, bus.p0_err}); else n_pass++;
        n_checks++; if (bus.p0_rdata !== 32'h0) $display("FAIL midrst_rdata got %h want 0", bus.p0_rdata); else n_pass++;
        n_checks++; if ({bus.p0_gnt, bus.m_we} !== 2'b00) $display("FAIL midrst_gnt_we got %b want 00", {bus.p0_gnt, bus.m_we}); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.m_a !== 32'h0) $display("FAIL midrst_m_a got %h want 0", bus.m_a); else n_pass++;
        @(negedge clk);
        clear_reqs();
        reset_n = 1;
        model_access(0, 32'h10, 32'h0, 3'b010, xe, xmwe, xrd);
        access(0, 0, 32'h10, 32'h0, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if (rd !== old10) $display("FAIL midrst_no_write got %h want %h", rd, old10); else n_pass++;
        n_checks++; if ({g, rv, e} !== 3'b110) $display("FAIL midrst_first_access got %b want 110", {g, rv, e}); else n_pass++;
        model_access(1, 32'h10, 32'h0BADF00D, 3'b010, xe, xmwe, xrd);
        access(0, 1, 32'h10, 32'h0BADF00D, 3'b010, g, mwe, ma, rv, e, rd, orv);
        model_access(0, 32'h10, 32'h0, 3'b010, xe, xmwe, xrd);
        access(1, 0, 32'h10, 32'h0, 3'b010, g, mwe, ma, rv, e, rd, orv);
        n_checks++; if (rd !== 32'h0BADF00D) $display("FAIL midrst_after_rdata got %h want 0badf00d", rd); else n_pass++;
    endtask

    task automatic test_idle();
        clear_reqs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.m_we} !== 3'b000) $display("FAIL idle_gnt_we got %b want 000", {bus.p0_gnt, bus.p1_gnt, bus.m_we}); else n_pass++;
            n_checks++; if (bus.m_a !== 32'h0) $display("FAIL idle_m_a got %h want 0", bus.m_a); else n_pass++;
            @(posedge clk);
            #1;
            n_checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) $display("FAIL idle_rvalid got %b want 00", {bus.p0_rvalid, bus.p1_rvalid}); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_lanes();
        test_misaligned();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory. It shares `dmem` between the pipeline's memory stage (port 0) and a secondary master such as a debug or DMA engine (port 1). It grants at most one access per cycle and drives the memory's write-enable, address, write-data and size-control inputs. It registers the read response and flags misaligned accesses, which it blocks.

## Interface

Parameters:
- `MAX_WAIT`, default 4: number of consecutive cycles port 1 may be refused before it is forced to win (range 1..15).

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset_n`  in  1  — reset, asynchronous, active-low.
- `p0_req`, `p1_req`  in  1  — access request; held until granted.
- `p0_we`, `p1_we`  in  1  — 1 = store, 0 = load.
- `p0_addr`, `p1_addr`  in  32  — byte address.
- `p0_wdata`, `p1_wdata`  in  32  — store data, right-aligned (byte in [7:0], half in [15:0]).
- `p0_size`, `p1_size`  in  3  — 000 = byte, 001 = half, any other value = word (same encoding as the dmem size control).
- `p0_gnt`, `p1_gnt`  out  1  — combinational grant; the access is taken at the rising edge where gnt=1.
- `p0_rvalid`, `p1_rvalid`  out  1  — one-cycle completion pulse, registered.
- `p0_rdata`, `p1_rdata`  out  32  — raw read word, registered; requester does lane select/extension.
- `p0_err`, `p1_err`  out  1  — misalignment flag, valid with rvalid.
- `m_we`  out  1  — to dmem write enable.
- `m_a`  out  32  — to dmem address.
- `m_wd`  out  32  — to dmem write data.
- `m_DextControl`  out  3  — to dmem size control.
- `m_rd`  in  32  — dmem asynchronous read data.

## Operation

- Arbitration, evaluated combinationally each cycle:
  - Port 0 has priority.
  - Port 1 wins if port 0 is idle, or if `wait_cnt == MAX_WAIT`.
  - Exactly one of `p0_gnt`/`p1_gnt` is high when any request is present; neither is high otherwise.
  - Both grants are forced to 0 while `reset_n` is low.
- Starvation counter `wait_cnt` (4 bits):
  - Increments each cycle `p1_req && !p1_gnt`, saturating at `MAX_WAIT`.
  - Clears when `p1_gnt` is high or `p1_req` is low.
  - Port 0 is therefore refused for exactly one cycle after port 1 has been refused `MAX_WAIT` consecutive cycles.
- Memory drive:
  - When a port is granted, `m_a`, `m_wd` and `m_DextControl` come from that port.
  - When no port is granted, these outputs drive 0.
  - `m_we = gnt && we && !err`.
- Misalignment, computed from the granted address and size:
  - `err = (size==001 && addr[1:0]==11) || (size∉{000,001} && addr[1:0]!=00)`.
  - Byte accesses never err.
  - An erroring access is still granted and completed, but never writes memory.
- Response:
  - At the edge ending a granted cycle, the granted port's `rvalid` is set to 1 for one cycle.
  - Its `err` is set to the computed flag.
  - Its `rdata` is set to `m_rd` for error-free loads, and to 0 for stores or errors.
  - The other port's `rvalid` and `err` are 0 that cycle; its `rdata` holds its previous value.
- States: none beyond `wait_cnt` and the response registers; the block is a single-cycle-per-access scheduler.

## Timing

- Reset values: all `rvalid`=0, all `err`=0, all `rdata`=0, `wait_cnt`=0. Combinational outputs (`gnt`, `m_we`, `m_a`, `m_wd`, `m_DextControl`) are 0 while `reset_n` is low.
- Grant latency: 0 cycles, same cycle as `req` if the port wins. Memory write occurs at that same edge.
- Response latency: `rvalid` 1 cycle after the grant cycle.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating ports are allowed with no idle cycle.
- Simultaneous requests: port 0 is granted unless `wait_cnt == MAX_WAIT`.
- Reset asserted mid-access: no write is performed at any edge while `reset_n` is low. Pending responses are discarded. After `reset_n` deasserts, arbitration restarts with `wait_cnt`=0.
- Requesters must hold `addr`/`we`/`wdata`/`size` stable while `req`=1 and `gnt`=0. The block does not register request fields.

## Test plan

- Single port-0 store then load: sw 0xDEADBEEF @0x10, then lw @0x10 → `p0_gnt` same cycle each, `p0_rvalid` next cycle, `p0_rdata`=0xDEADBEEF, `p0_err`=0.
- Byte/half lanes: sb 0xAA @0x21, then sh 0x1234 @0x22, then lw @0x20 → `p0_rdata[31:8]`=0x1234AA, all `err`=0.
- Starvation with `MAX_WAIT`=4: both ports request continuously → p0 granted 4 cycles, p1 on the 5th, pattern repeats; `wait_cnt` never exceeds 4.
- Misaligned: sw @0x13 and sh @0x17 from p1 → granted, `m_we`=0, `p1_err`=1 with `rvalid`, memory words at 0x10 and 0x14 unchanged.
- Reset mid-traffic: drop `reset_n` while p0 sw is requested → no write, all `rvalid`/`err`/`rdata`=0 asynchronously; after release, the first access completes normally.
- Idle: no requests → both `gnt`=0, `m_we`=0, `m_a`=0, no `rvalid` pulses.
